// File: rtl/drfm_sdram_pkg.sv
// Shared types and constants for the DRFM SDRAM port arbiter.
package drfm_sdram_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 16;

    typedef logic [1:0] gnt_state_t;

    localparam gnt_state_t ST_IDLE   = 2'd0;
    localparam gnt_state_t ST_GNT_WR = 2'd1;
    localparam gnt_state_t ST_GNT_RD = 2'd2;

    localparam logic LAST_RD = 1'b0;
    localparam logic LAST_WR = 1'b1;

    localparam logic [1:0] AV_BE_N_IDLE = 2'b11;
    localparam logic [1:0] AV_BE_N_READ = 2'b00;

    // On a simultaneous request the side that did not hold the last grant wins.
    function automatic gnt_state_t tie_winner(input logic last_gnt);
        return (last_gnt == LAST_RD) ? ST_GNT_WR : ST_GNT_RD;
    endfunction

endpackage

// File: rtl/drfm_updown_counter.sv
// Saturating up/down counter with a sticky flag for decrements requested at zero.
module drfm_updown_counter
#(
    parameter int  MAX_COUNT = 7,
    localparam int CNT_W     = $clog2(MAX_COUNT + 1)
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_underflow;
    logic             w_up;
    logic             w_down;

    assign w_up   = i_inc && (r_count != CNT_MAX);
    assign w_down = i_dec && (r_count != '0);

    // Next count: simultaneous up and down cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_up, w_down})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Count and sticky underflow registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (i_dec && (r_count == '0)) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/drfm_sdram_arbiter.sv
// Shares one Avalon-MM SDRAM controller port between the capture writer and playback reader.
module drfm_sdram_arbiter
    import drfm_sdram_pkg::*;
#(
    parameter int  ADDR_W      = ADDR_W_DEF,
    parameter int  DATA_W      = DATA_W_DEF,
    parameter int  BURST_MAX   = 8,
    parameter int  MAX_PENDING = 7,
    localparam int PEND_W      = $clog2(MAX_PENDING + 1)
)(
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_be,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [PEND_W-1:0] rd_pending,
    output logic              rd_err,
    output logic [ADDR_W-1:0] av_address,
    output logic [1:0]        av_byteenable_n,
    output logic              av_chipselect,
    output logic [DATA_W-1:0] av_writedata,
    output logic              av_read_n,
    output logic              av_write_n,
    input  logic [DATA_W-1:0] av_readdata,
    input  logic              av_readdatavalid,
    input  logic              av_waitrequest
);

    localparam int               BCNT_W     = $clog2(BURST_MAX + 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_MAX - 1);
    localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(MAX_PENDING);

    gnt_state_t        r_state;
    gnt_state_t        w_state_nxt;
    logic              r_last_gnt;
    logic [BCNT_W-1:0] r_burst_cnt;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [PEND_W-1:0] w_rd_pending;
    logic              w_wr_cmd;
    logic              w_rd_cmd;
    logic              w_cmd;
    logic              w_accept;
    logic              w_burst_done;

    // A read is held off while the controller already has the maximum outstanding.
    assign w_wr_cmd     = (r_state == ST_GNT_WR) && wr_req;
    assign w_rd_cmd     = (r_state == ST_GNT_RD) && rd_req && (w_rd_pending < PEND_LIMIT);
    assign w_cmd        = w_wr_cmd || w_rd_cmd;
    assign w_accept     = w_cmd && !av_waitrequest;
    assign w_burst_done = w_accept && (r_burst_cnt == BURST_LAST);

    assign wr_ack = w_wr_cmd && !av_waitrequest;
    assign rd_ack = w_rd_cmd && !av_waitrequest;

    // Grant sequencing; a command stalled by waitrequest keeps the grant.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (wr_req && rd_req) begin
                    w_state_nxt = tie_winner(r_last_gnt);
                end else if (wr_req) begin
                    w_state_nxt = ST_GNT_WR;
                end else if (rd_req) begin
                    w_state_nxt = ST_GNT_RD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT_WR: begin
                if ((w_burst_done || !w_cmd) && rd_req) begin
                    w_state_nxt = ST_GNT_RD;
                end else if (!w_cmd) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GNT_WR;
                end
            end
            ST_GNT_RD: begin
                if ((w_burst_done || !w_cmd) && wr_req) begin
                    w_state_nxt = ST_GNT_WR;
                end else if (!w_cmd) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GNT_RD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, last-grant memory and per-grant accept counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= ST_IDLE;
            r_last_gnt  <= LAST_RD;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_GNT_WR) begin
                r_last_gnt <= LAST_WR;
            end else if (w_state_nxt == ST_GNT_RD) begin
                r_last_gnt <= LAST_RD;
            end
            if (w_state_nxt != r_state) begin
                r_burst_cnt <= '0;
            end else if (w_accept && (r_burst_cnt != BURST_LAST)) begin
                r_burst_cnt <= r_burst_cnt + BCNT_W'(1);
            end
        end
    end

    // Avalon command mux; undriven cycles present the idle bus pattern.
    always_comb begin
        av_chipselect   = 1'b0;
        av_read_n       = 1'b1;
        av_write_n      = 1'b1;
        av_byteenable_n = AV_BE_N_IDLE;
        av_address      = '0;
        av_writedata    = '0;
        if (w_wr_cmd) begin
            av_chipselect   = 1'b1;
            av_write_n      = 1'b0;
            av_byteenable_n = ~wr_be;
            av_address      = wr_addr;
            av_writedata    = wr_data;
        end else if (w_rd_cmd) begin
            av_chipselect   = 1'b1;
            av_read_n       = 1'b0;
            av_byteenable_n = AV_BE_N_READ;
            av_address      = rd_addr;
        end else begin
            av_chipselect   = 1'b0;
        end
    end

    // Read return path, one register stage.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= av_readdatavalid;
            if (av_readdatavalid) begin
                r_rd_data <= av_readdata;
            end
        end
    end

    drfm_updown_counter #(
        .MAX_COUNT (MAX_PENDING)
    ) u_rd_pending (
        .i_clk       (clk_clk),
        .i_rst_n     (reset_reset_n),
        .i_inc       (rd_ack),
        .i_dec       (av_readdatavalid),
        .o_count     (w_rd_pending),
        .o_underflow (rd_err)
    );

    assign rd_pending = w_rd_pending;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;

endmodule

// File: tb/tb_drfm_sdram_arbiter.sv
// Directed bench for drfm_sdram_arbiter: vector table plus multi-cycle sequences.
module tb_drfm_sdram_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_req, rd_req, wr_ack, rd_ack;
    logic [AW-1:0] wr_addr, rd_addr, av_address;
    logic [DW-1:0] wr_data, rd_data, av_writedata, av_readdata;
    logic [1:0]    wr_be, av_byteenable_n;
    logic          rd_valid, rd_err, av_chipselect, av_read_n, av_write_n;
    logic          av_readdatavalid, av_waitrequest;
    logic [PW-1:0] rd_pending;

    logic          tb_rdv;
    logic [DW-1:0] tb_rdata;
    logic          ctl_en;
    logic [1:0]    pipe;

    int n_cmp  = 0;
    int n_fail = 0;
    int rv_cnt = 0;

    always #5 clk = ~clk;

    // Simple controller model: read data returns two cycles after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= 2'b00;
        else        pipe <= {pipe[0], rd_ack & ctl_en};
    end

    assign av_readdatavalid = ctl_en ? pipe[1] : tb_rdv;
    assign av_readdata      = ctl_en ? 16'hD00D : tb_rdata;

    drfm_sdram_arbiter dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_be            (wr_be),
        .wr_ack           (wr_ack),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_ack           (rd_ack),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_pending       (rd_pending),
        .rd_err           (rd_err),
        .av_address       (av_address),
        .av_byteenable_n  (av_byteenable_n),
        .av_chipselect    (av_chipselect),
        .av_writedata     (av_writedata),
        .av_read_n        (av_read_n),
        .av_write_n       (av_write_n),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid),
        .av_waitrequest   (av_waitrequest)
    );

    typedef struct {
        logic wr_req; logic [AW-1:0] wr_addr; logic [DW-1:0] wr_data; logic [1:0] wr_be;
        logic rd_req; logic [AW-1:0] rd_addr; logic wait_r; logic rdv; logic [DW-1:0] rdata;
        logic x_wr_ack; logic x_rd_ack; logic x_cs; logic x_wn; logic x_rn; logic [1:0] x_be_n;
        logic [AW-1:0] x_addr; logic [DW-1:0] x_wdata; logic x_rv; logic [DW-1:0] x_rdata;
        logic [PW-1:0] x_pend; logic x_err;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [127:0] outs();
        return {59'd0, wr_ack, rd_ack, av_chipselect, av_write_n, av_read_n, av_byteenable_n,
                av_address, av_writedata, rd_valid, rd_data, rd_pending, rd_err};
    endfunction

    function automatic logic [127:0] exp_bundle(
        input logic a_wr_ack, input logic a_rd_ack, input logic a_cs, input logic a_wn,
        input logic a_rn, input logic [1:0] a_be_n, input logic [AW-1:0] a_addr,
        input logic [DW-1:0] a_wdata, input logic a_rv, input logic [DW-1:0] a_rdata,
        input logic [PW-1:0] a_pend, input logic a_err);
        return {59'd0, a_wr_ack, a_rd_ack, a_cs, a_wn, a_rn, a_be_n, a_addr, a_wdata,
                a_rv, a_rdata, a_pend, a_err};
    endfunction

    function automatic logic [127:0] idle_exp(input logic a_rv, input logic [DW-1:0] a_rdata,
                                              input logic [PW-1:0] a_pend, input logic a_err);
        return exp_bundle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, a_rv, a_rdata, a_pend, a_err);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = 2'b00;
        rd_req = 1'b0; rd_addr = '0; av_waitrequest = 1'b0;
        tb_rdv = 1'b0; tb_rdata = '0; ctl_en = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset", outs(), idle_exp(1'b0, 16'h0, 3'd0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();

        vecs[0]  = '{1'b0, 25'h0, 16'h0, 2'b00, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 16'h0, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 25'h123, 16'hBEEF, 2'b11, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 16'h0, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 25'h123, 16'hBEEF, 2'b11, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 25'h123, 16'hBEEF, 1'b0, 16'h0, 3'd0, 1'b0};
        vecs[3]  = '{1'b0, 25'h0, 16'h0, 2'b00, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 16'h0, 3'd0, 1'b0};
        vecs[4]  = '{1'b0, 25'h0, 16'h0, 2'b00, 1'b1, 25'h456, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 16'h0, 3'd0, 1'b0};
        vecs[5]  = '{1'b0, 25'h0, 16'h0, 2'b00, 1'b1, 25'h456, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 25'h456, 16'h0, 1'b0, 16'h0, 3'd0, 1'b0};
        vecs[6]  = '{1'b0, 25'h0, 16'h0, 2'b00, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 16'h0, 3'd1, 1'b0};
        vecs[7]  = '{1'b0, 25'h0, 16'h0, 2'b00, 1'b0, 25'h0, 1'b0, 1'b1, 16'hA5A5,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 16'h0, 3'd1, 1'b0};
        vecs[8]  = '{1'b0, 25'h0, 16'h0, 2'b00, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b1, 16'hA5A5, 3'd0, 1'b0};
        vecs[9]  = '{1'b0, 25'h0, 16'h0, 2'b00, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 16'hA5A5, 3'd0, 1'b0};
        vecs[10] = '{1'b1, 25'h1FFFFFF, 16'h0001, 2'b01, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 16'hA5A5, 3'd0, 1'b0};
        vecs[11] = '{1'b1, 25'h1FFFFFF, 16'h0001, 2'b01, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 25'h1FFFFFF, 16'h0001, 1'b0, 16'hA5A5, 3'd0, 1'b0};
        vecs[12] = '{1'b0, 25'h0, 16'h0, 2'b00, 1'b0, 25'h0, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 16'hA5A5, 3'd0, 1'b0};

        // Table: single write, single read with data return, partial byte enables.
        reset_dut();
        for (int i = 0; i < 13; i++) begin
            step();
            wr_req = vecs[i].wr_req; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            wr_be = vecs[i].wr_be; rd_req = vecs[i].rd_req; rd_addr = vecs[i].rd_addr;
            av_waitrequest = vecs[i].wait_r; tb_rdv = vecs[i].rdv; tb_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(),
                exp_bundle(vecs[i].x_wr_ack, vecs[i].x_rd_ack, vecs[i].x_cs, vecs[i].x_wn,
                           vecs[i].x_rn, vecs[i].x_be_n, vecs[i].x_addr, vecs[i].x_wdata,
                           vecs[i].x_rv, vecs[i].x_rdata, vecs[i].x_pend, vecs[i].x_err));
        end

        // Write stalled by waitrequest for five cycles with a competing read.
        reset_dut();
        step();
        wr_req = 1'b1; wr_addr = 25'h0ABCDEF; wr_data = 16'h1234; wr_be = 2'b11;
        rd_req = 1'b1; rd_addr = 25'h77; av_waitrequest = 1'b1;
        @(negedge clk);
        chk("wait_c0", outs(), idle_exp(1'b0, 16'h0, 3'd0, 1'b0));
        for (int i = 1; i <= 5; i++) begin
            step();
            @(negedge clk);
            chk("wait_hold", outs(), exp_bundle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 25'h0ABCDEF,
                                                16'h1234, 1'b0, 16'h0, 3'd0, 1'b0));
        end
        step();
        av_waitrequest = 1'b0;
        @(negedge clk);
        chk("wait_ack", outs(), exp_bundle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 25'h0ABCDEF,
                                           16'h1234, 1'b0, 16'h0, 3'd0, 1'b0));
        step();
        wr_req = 1'b0;
        @(negedge clk);
        chk("wait_post", outs(), idle_exp(1'b0, 16'h0, 3'd0, 1'b0));
        step();
        @(negedge clk);
        chk("wait_rd", outs(), exp_bundle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 25'h77,
                                          16'h0, 1'b0, 16'h0, 3'd0, 1'b0));
        step();
        rd_req = 1'b0;
        @(negedge clk);
        chk("wait_end", outs(), idle_exp(1'b0, 16'h0, 3'd1, 1'b0));

        // Outstanding-read limit, write takes the port, one return resumes reads.
        reset_dut();
        step();
        rd_req = 1'b1; rd_addr = 25'h10;
        @(negedge clk);
        chk("pend_c0", outs(), idle_exp(1'b0, 16'h0, 3'd0, 1'b0));
        for (int i = 1; i <= 7; i++) begin
            step();
            @(negedge clk);
            chk("pend_rd", outs(), exp_bundle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 25'h10,
                                              16'h0, 1'b0, 16'h0, 3'(i - 1), 1'b0));
        end
        step();
        wr_req = 1'b1; wr_addr = 25'h20; wr_data = 16'hCAFE; wr_be = 2'b11;
        @(negedge clk);
        chk("pend_full", outs(), idle_exp(1'b0, 16'h0, 3'd7, 1'b0));
        step();
        @(negedge clk);
        chk("pend_wr", outs(), exp_bundle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 25'h20,
                                          16'hCAFE, 1'b0, 16'h0, 3'd7, 1'b0));
        step();
        wr_req = 1'b0; tb_rdv = 1'b1; tb_rdata = 16'h5A5A;
        @(negedge clk);
        chk("pend_sw", outs(), idle_exp(1'b0, 16'h0, 3'd7, 1'b0));
        step();
        tb_rdv = 1'b0;
        @(negedge clk);
        chk("pend_resume", outs(), exp_bundle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 25'h10,
                                              16'h0, 1'b1, 16'h5A5A, 3'd6, 1'b0));
        step();
        @(negedge clk);
        chk("pend_refull", outs(), idle_exp(1'b0, 16'h5A5A, 3'd7, 1'b0));

        // Read data with nothing outstanding.
        reset_dut();
        step();
        tb_rdv = 1'b1; tb_rdata = 16'h1111;
        @(negedge clk);
        chk("err_pre", outs(), idle_exp(1'b0, 16'h0, 3'd0, 1'b0));
        step();
        tb_rdv = 1'b0;
        @(negedge clk);
        chk("err_set", outs(), idle_exp(1'b1, 16'h1111, 3'd0, 1'b1));
        step();
        step();
        @(negedge clk);
        chk("err_sticky", outs(), idle_exp(1'b0, 16'h1111, 3'd0, 1'b1));

        // Reset in the middle of a stalled write with three reads outstanding.
        reset_dut();
        step();
        rd_req = 1'b1; rd_addr = 25'h30;
        step();
        step();
        step();
        @(negedge clk);
        chk("mid_pend", 128'(rd_pending), 128'(3'd2));
        step();
        rd_req = 1'b0; wr_req = 1'b1; wr_addr = 25'h40; wr_data = 16'h4444; wr_be = 2'b11;
        av_waitrequest = 1'b1;
        step();
        @(negedge clk);
        chk("mid_wr", outs(), exp_bundle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 25'h40,
                                         16'h4444, 1'b0, 16'h0, 3'd3, 1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst", outs(), idle_exp(1'b0, 16'h0, 3'd0, 1'b0));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst", outs(), idle_exp(1'b0, 16'h0, 3'd0, 1'b0));

        // Both requesters held: alternating bursts of eight, write first.
        reset_dut();
        ctl_en = 1'b1;
        step();
        wr_req = 1'b1; wr_addr = 25'h100; wr_data = 16'h0F0F; wr_be = 2'b11;
        rd_req = 1'b1; rd_addr = 25'h200;
        @(negedge clk);
        chk("burst_c0", 128'({wr_ack, rd_ack}), 128'(2'b00));
        rv_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("burst_k%0d", k), 128'({wr_ack, rd_ack}),
                128'((((k / 8) % 2) == 0) ? 2'b10 : 2'b01));
            rv_cnt += int'(rd_valid);
        end
        step();
        wr_req = 1'b0; rd_req = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            rv_cnt += int'(rd_valid);
            @(posedge clk);
        end
        chk("burst_rv", 128'(rv_cnt), 128'(16));
        chk("burst_drain", 128'(rd_pending), 128'(3'd0));
        ctl_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
